// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - tagged BTB with saturating direction counters; optional gshare indexing via BTB_GSHARE_EN
module branch_target_predictor #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 64,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 2 ** (CTR_W - 1),
  parameter int HIST_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_valid,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_mispredict,
  output logic                init_done,
  output logic [31:0]         mispredict_cnt
);

  localparam int TAG_W = PC_WIDTH - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_INIT_V = CTR_W'(CTR_INIT);
  localparam logic [CTR_W-1:0] CTR_MAX    = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;

  logic                valid_mem  [DEPTH];
  logic [TAG_W-1:0]    tag_mem    [DEPTH];
  logic [PC_WIDTH-1:0] target_mem [DEPTH];
  logic [CTR_W-1:0]    ctr_mem    [DEPTH];

  logic [IDX_W-1:0] l_idx, u_idx, l_cidx, u_cidx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             run, u_hit;
  logic [CTR_W-1:0] ctr_cur, ctr_next;
  logic             unused_pc_bits;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[PC_WIDTH-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[PC_WIDTH-1:IDX_W+2];
  assign run   = (state == S_RUN);
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

`ifdef BTB_GSHARE_EN
  logic [HIST_W-1:0] hist;

  // only direction counters are hashed with history; tag/target/valid stay on the plain index
  assign l_cidx = l_idx ^ IDX_W'(hist);
  assign u_cidx = u_idx ^ IDX_W'(hist);

  // global history: shift in each resolved outcome while running
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
    end else if (run && upd_valid) begin
      hist <= HIST_W'({hist, upd_taken});
    end
  end
`else
  logic [31:0] unused_hist_w;

  assign unused_hist_w = 32'(HIST_W);
  assign l_cidx = l_idx;
  assign u_cidx = u_idx;
`endif

  // zero-latency fetch lookup; reads pre-update contents, no bypass from a same-cycle update
  always_comb begin
    pred_hit    = run & lookup_valid & valid_mem[l_idx] & (tag_mem[l_idx] == l_tag);
    pred_taken  = pred_hit & ctr_mem[l_cidx][CTR_W-1];
    pred_target = pred_hit ? target_mem[l_idx] : '0;
  end

  // resolved-branch hit test and saturating counter step
  always_comb begin
    u_hit   = valid_mem[u_idx] & (tag_mem[u_idx] == u_tag);
    ctr_cur = ctr_mem[u_cidx];
    if (upd_taken) begin
      ctr_next = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + CTR_W'(1);
    end else begin
      ctr_next = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_W'(1);
    end
  end

  // init sweep walks every entry once, then the predictor runs until the next reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      ptr       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          ptr <= ptr + IDX_W'(1);
          if (ptr == IDX_W'(DEPTH - 1)) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          state     <= S_RUN;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // table writes: init sweep clears valid and seeds counters (hashed lookups may read any counter), else apply updates
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      valid_mem[ptr] <= 1'b0;
      ctr_mem[ptr]   <= CTR_INIT_V;
    end else if (upd_valid) begin
      if (u_hit) begin
        ctr_mem[u_cidx] <= ctr_next;
        if (upd_taken) begin
          target_mem[u_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        valid_mem[u_idx]  <= 1'b1;
        tag_mem[u_idx]    <= u_tag;
        target_mem[u_idx] <= upd_target;
        ctr_mem[u_cidx]   <= CTR_INIT_V;
      end
    end
  end

  // mispredict counter runs in every state and saturates at all ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredict_cnt <= '0;
    end else if (upd_valid && upd_mispredict && (mispredict_cnt != '1)) begin
      mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed bench for branch_target_predictor (DEPTH=64, CTR_W=2)
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic        init_done;
  logic [31:0] mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  branch_target_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_valid   (lookup_valid),
    .lookup_pc      (lookup_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .init_done      (init_done),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic drive_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic misp);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt; upd_mispredict = misp;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic drive_lookup(input logic [31:0] pc);
    @(negedge clk);
    lookup_valid = 1'b1; lookup_pc = pc;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    lookup_valid = 1'b1; lookup_pc = 32'h40;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %0b want 0", init_done); end
    n_checks++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL rst_pred_hit: got %0b want 0", pred_hit); end
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_pred_taken: got %0b want 0", pred_taken); end
    n_checks++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL rst_pred_target: got %0h want 0", pred_target); end
    n_checks++; if (mispredict_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", mispredict_cnt); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL init_len cycle %0d: got %0b want 0", i, init_done); end
      n_checks++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL init_lookup cycle %0d: got %0b want 0", i, pred_hit); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_after_64: got %0b want 1", init_done); end
    lookup_valid = 1'b0;
  endtask

  task automatic test_counter;
    drive_update(32'h100, 1'b1, 32'h80, 1'b0);
    drive_lookup(32'h100);
    n_checks++; if (pred_hit !== 1'b1) begin n_fail++; $display("FAIL alloc_hit: got %0b want 1", pred_hit); end
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_taken: got %0b want 1", pred_taken); end
    n_checks++; if (pred_target !== 32'h80) begin n_fail++; $display("FAIL alloc_target: got %0h want 80", pred_target); end
    lookup_valid = 1'b0;
    #1;
    n_checks++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL no_lookup_hit: got %0b want 0", pred_hit); end
    n_checks++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL no_lookup_target: got %0h want 0", pred_target); end
    repeat (2) drive_update(32'h100, 1'b0, 32'h0, 1'b0);
    drive_lookup(32'h100);
    n_checks++; if (pred_hit !== 1'b1) begin n_fail++; $display("FAIL nt2_hit: got %0b want 1", pred_hit); end
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt2_taken: got %0b want 0", pred_taken); end
    repeat (3) drive_update(32'h100, 1'b0, 32'h0, 1'b0);
    drive_update(32'h100, 1'b1, 32'h80, 1'b0);
    drive_lookup(32'h100);
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL floor_then_t1: got %0b want 0", pred_taken); end
    drive_update(32'h100, 1'b1, 32'h80, 1'b0);
    drive_lookup(32'h100);
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL floor_then_t2: got %0b want 1", pred_taken); end
    drive_update(32'h200, 1'b0, 32'h500, 1'b0);
    drive_lookup(32'h100);
    n_checks++; if (pred_hit !== 1'b1) begin n_fail++; $display("FAIL nt_miss_keeps: got %0b want 1", pred_hit); end
    drive_lookup(32'h200);
    n_checks++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL nt_miss_noalloc: got %0b want 0", pred_hit); end
    lookup_valid = 1'b0;
  endtask

  task automatic test_saturate;
    repeat (3) drive_update(32'h100, 1'b1, 32'h80, 1'b0);
    drive_update(32'h100, 1'b1, 32'h1234, 1'b0);
    drive_update(32'h100, 1'b0, 32'h0, 1'b0);
    drive_lookup(32'h100);
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_then_nt: got %0b want 1", pred_taken); end
    n_checks++; if (pred_target !== 32'h1234) begin n_fail++; $display("FAIL target_overwrite: got %0h want 1234", pred_target); end
    drive_update(32'h100, 1'b0, 32'h0, 1'b0);
    drive_lookup(32'h100);
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_then_nt2: got %0b want 0", pred_taken); end
    lookup_valid = 1'b0;
  endtask

  task automatic test_alias;
    drive_update(32'h200, 1'b1, 32'h300, 1'b0);
    drive_lookup(32'h100);
    n_checks++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL alias_old_hit: got %0b want 0", pred_hit); end
    n_checks++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL alias_old_target: got %0h want 0", pred_target); end
    drive_lookup(32'h200);
    n_checks++; if (pred_hit !== 1'b1) begin n_fail++; $display("FAIL alias_new_hit: got %0b want 1", pred_hit); end
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_new_taken: got %0b want 1", pred_taken); end
    n_checks++; if (pred_target !== 32'h300) begin n_fail++; $display("FAIL alias_new_target: got %0h want 300", pred_target); end
    lookup_valid = 1'b0;
    drive_update(32'h100, 1'b1, 32'h80, 1'b0);
    drive_update(32'h100, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    lookup_valid = 1'b1; lookup_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80; upd_mispredict = 1'b0;
    #1;
    n_checks++; if (pred_hit !== 1'b1) begin n_fail++; $display("FAIL same_cycle_hit: got %0b want 1", pred_hit); end
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL same_cycle_old: got %0b want 0", pred_taken); end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL same_cycle_next: got %0b want 1", pred_taken); end
    lookup_valid = 1'b0;
  endtask

`ifdef BTB_GSHARE_EN
  task automatic test_gshare;
    drive_update(32'h10C, 1'b1, 32'h40, 1'b0);
    repeat (6) drive_update(32'h10C, 1'b0, 32'h0, 1'b0);
    repeat (2) drive_update(32'h100, 1'b1, 32'h80, 1'b0);
    drive_lookup(32'h100);
    n_checks++; if (pred_hit !== 1'b1) begin n_fail++; $display("FAIL gshare_hit: got %0b want 1", pred_hit); end
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL gshare_idx0_xor3: got %0b want 0", pred_taken); end
    drive_lookup(32'h10C);
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL gshare_idx3_xor3: got %0b want 1", pred_taken); end
    n_checks++; if (pred_target !== 32'h40) begin n_fail++; $display("FAIL gshare_target: got %0h want 40", pred_target); end
    lookup_valid = 1'b0;
  endtask
`endif

  task automatic test_mispredict;
    repeat (2) drive_update(32'h400, 1'b0, 32'h0, 1'b1);
    n_checks++; if (mispredict_cnt !== 32'd2) begin n_fail++; $display("FAIL misp_cnt2: got %0d want 2", mispredict_cnt); end
    @(negedge clk);
    upd_valid = 1'b0; upd_mispredict = 1'b1;
    @(posedge clk);
    #1;
    upd_mispredict = 1'b0;
    n_checks++; if (mispredict_cnt !== 32'd2) begin n_fail++; $display("FAIL misp_no_valid: got %0d want 2", mispredict_cnt); end
    repeat (3) drive_update(32'h400, 1'b0, 32'h0, 1'b1);
    n_checks++; if (mispredict_cnt !== 32'd5) begin n_fail++; $display("FAIL misp_cnt5: got %0d want 5", mispredict_cnt); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (mispredict_cnt !== 32'd0) begin n_fail++; $display("FAIL misp_rst_clear: got %0d want 0", mispredict_cnt); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) drive_update(32'h180, 1'b1, 32'h999, 1'b1);
    n_checks++; if (mispredict_cnt !== 32'd3) begin n_fail++; $display("FAIL misp_in_init: got %0d want 3", mispredict_cnt); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL mid_init_done: got %0b want 0", init_done); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (mispredict_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_init_rst_cnt: got %0d want 0", mispredict_cnt); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reinit_len cycle %0d: got %0b want 0", i, init_done); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL reinit_done: got %0b want 1", init_done); end
    drive_lookup(32'h180);
    n_checks++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL init_update_dropped: got %0b want 0", pred_hit); end
    lookup_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    lookup_valid = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    test_reset;
`ifdef BTB_GSHARE_EN
    test_gshare;
`else
    test_counter;
    test_saturate;
    test_alias;
    test_same_cycle;
`endif
    test_mispredict;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
